// File: rtl/perf_pkg.sv
// perf_pkg: shared types and defaults for the performance monitor.
// Imported by the interface, the counter and the top.
package perf_pkg;

  localparam int NUM_EVT_DEF = 2;
  localparam int CNT_W_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } perf_state_e;

endpackage

// File: rtl/perf_monitor_if.sv
// perf_monitor_if: control, event and readout bundle of the monitor.
// master drives stimulus and reads results; slave is the monitor.
interface perf_monitor_if
  import perf_pkg::*;
#(
  parameter int NUM_EVT = NUM_EVT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int SEL_W   = $clog2(NUM_EVT + 1)
);

  logic               start_i;
  logic               stop_i;
  logic               clear_i;
  logic [NUM_EVT-1:0] evt_i;
  logic [NUM_EVT-1:0] evt_mask_i;
  logic [CNT_W-1:0]   limit_i;
  logic [SEL_W-1:0]   rd_sel_i;
  logic [CNT_W-1:0]   rd_data_o;
  logic               running_o;
  logic               done_o;
  logic [NUM_EVT:0]   ovf_o;

  modport master (
    output start_i,
    output stop_i,
    output clear_i,
    output evt_i,
    output evt_mask_i,
    output limit_i,
    output rd_sel_i,
    input  rd_data_o,
    input  running_o,
    input  done_o,
    input  ovf_o
  );

  modport slave (
    input  start_i,
    input  stop_i,
    input  clear_i,
    input  evt_i,
    input  evt_mask_i,
    input  limit_i,
    input  rd_sel_i,
    output rd_data_o,
    output running_o,
    output done_o,
    output ovf_o
  );

endinterface

// File: rtl/perf_counter.sv
// perf_counter: saturating up-counter with clear and sticky overflow.
// Overflow flags an increment that arrived while already at full scale.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_q;
  logic             ovf_d;

  // Next count: clear wins over increment; hold at full scale.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (cnt_q == MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // Counter and overflow registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: run-controlled cycle and event counters with readout.
// Slot 0 is the cycle counter; slot k+1 counts event channel k.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVT = NUM_EVT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  perf_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  perf_state_e state_q;
  perf_state_e state_d;

  logic [CNT_W-1:0] lim_q;
  logic [CNT_W-1:0] lim_d;
  logic [CNT_W-1:0] rd_q;
  logic [CNT_W-1:0] rd_d;

  logic start_q;
  logic arm_q;
  logic start_rise;
  logic launch;
  logic run;
  logic lim_hit;
  logic clr;

  logic [NUM_EVT:0]            inc;
  logic [NUM_EVT:0]            ovf;
  logic [NUM_EVT:0][CNT_W-1:0] cnt;

  // A start held high across reset must drop before it can launch.
  assign start_rise = bus.start_i & ~start_q & arm_q;

  assign run = (state_q == RUN);

  assign lim_hit = (lim_q != '0) &&
                   (cnt[0] == lim_q - ONE);

  // Next state and limit capture on launch.
  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    launch  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          state_d = RUN;
          lim_d   = bus.limit_i;
          launch  = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop_i || lim_hit) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, limit, start edge detector and readout registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lim_q   <= '0;
      start_q <= 1'b0;
      arm_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      start_q <= bus.start_i;
      arm_q   <= arm_q | ~bus.start_i;
      rd_q    <= rd_d;
    end
  end

  assign clr = bus.clear_i | launch;

  assign inc = {bus.evt_i & bus.evt_mask_i & {NUM_EVT{run}}, run};

  for (genvar k = 0; k <= NUM_EVT; k++) begin : g_cnt
    perf_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clr),
      .inc_i (inc[k]),
      .cnt_o (cnt[k]),
      .ovf_o (ovf[k])
    );
  end

  // Readout select; out-of-range selects read zero.
  always_comb begin
    rd_d = '0;
    for (int k = 0; k <= NUM_EVT; k++) begin
      if (int'(bus.rd_sel_i) == k) begin
        rd_d = cnt[k];
      end
    end
  end

  assign bus.rd_data_o = rd_q;
  assign bus.running_o = run;
  assign bus.done_o    = (state_q == DONE);
  assign bus.ovf_o     = ovf;

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: directed checks of perf_monitor at 32-bit and 8-bit widths.
// Each task drives one scenario and compares against hand-computed values.
module tb_perf_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  perf_monitor_if #(.NUM_EVT(2), .CNT_W(32)) b32 ();
  perf_monitor_if #(.NUM_EVT(2), .CNT_W(8))  b8 ();

  perf_monitor #(.NUM_EVT(2), .CNT_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b32)
  );

  perf_monitor #(.NUM_EVT(2), .CNT_W(8)) dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b8)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch32(input logic [31:0] lim);
    b32.limit_i = lim;
    b32.start_i = 1'b0;
    tick();
    b32.start_i = 1'b1;
    tick();
  endtask

  task automatic rd32(input logic [1:0] s, output logic [31:0] v);
    b32.rd_sel_i = s;
    tick();
    v = b32.rd_data_o;
  endtask

  task automatic rd8(input logic [1:0] s, output logic [7:0] v);
    b8.rd_sel_i = s;
    tick();
    v = b8.rd_data_o;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    tick(2);
    vecs++;
    if (b32.running_o !== 1'b0 || b32.done_o !== 1'b0) begin
      errs++;
      $display("FAIL reset_state run=%b done=%b want 0 0",
               b32.running_o, b32.done_o);
    end
    vecs++;
    if (b32.ovf_o !== 3'b000 || b32.rd_data_o !== 32'd0) begin
      errs++;
      $display("FAIL reset_out ovf=%b rd=%0d want 000 0",
               b32.ovf_o, b32.rd_data_o);
    end
    rst = 1'b0;
    rd32(2'd0, v);
    vecs++;
    if (v !== 32'd0 || b32.running_o !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle rd=%0d run=%b want 0 0",
               v, b32.running_o);
    end
  endtask

  task automatic test_limit();
    logic [31:0] v;
    b32.evt_mask_i = 2'b11;
    launch32(32'd10);
    for (int c = 1; c <= 10; c++) begin
      b32.evt_i = {1'b0, (c >= 2 && c <= 5)};
      if (c == 10) begin
        vecs++;
        if (b32.running_o !== 1'b1 || b32.done_o !== 1'b0) begin
          errs++;
          $display("FAIL limit_c10 run=%b done=%b want 1 0",
                   b32.running_o, b32.done_o);
        end
      end
      tick();
    end
    b32.evt_i = 2'b00;
    vecs++;
    if (b32.done_o !== 1'b1 || b32.running_o !== 1'b0) begin
      errs++;
      $display("FAIL limit_done done=%b run=%b want 1 0",
               b32.done_o, b32.running_o);
    end
    rd32(2'd0, v);
    vecs++;
    if (v !== 32'd10) begin
      errs++;
      $display("FAIL limit_cycle got %0d want 10", v);
    end
    rd32(2'd1, v);
    vecs++;
    if (v !== 32'd4) begin
      errs++;
      $display("FAIL limit_ch0 got %0d want 4", v);
    end
    rd32(2'd2, v);
    vecs++;
    if (v !== 32'd0) begin
      errs++;
      $display("FAIL limit_ch1 got %0d want 0", v);
    end
    rd32(2'd3, v);
    vecs++;
    if (v !== 32'd0 || b32.ovf_o !== 3'b000) begin
      errs++;
      $display("FAIL sel_oob rd=%0d ovf=%b want 0 000", v, b32.ovf_o);
    end
  endtask

  task automatic test_mask();
    logic [31:0] v;
    b32.evt_mask_i = 2'b10;
    launch32(32'd6);
    b32.evt_i = 2'b11;
    tick(6);
    b32.evt_i = 2'b00;
    b32.evt_mask_i = 2'b11;
    vecs++;
    if (b32.done_o !== 1'b1) begin
      errs++;
      $display("FAIL mask_done got %b want 1", b32.done_o);
    end
    rd32(2'd1, v);
    vecs++;
    if (v !== 32'd0) begin
      errs++;
      $display("FAIL mask_ch0 got %0d want 0", v);
    end
    rd32(2'd2, v);
    vecs++;
    if (v !== 32'd6) begin
      errs++;
      $display("FAIL mask_ch1 got %0d want 6", v);
    end
  endtask

  task automatic test_start_in_run();
    logic [31:0] v;
    launch32(32'd8);
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) b32.start_i = 1'b0;
      if (c == 4) b32.start_i = 1'b1;
      tick();
    end
    vecs++;
    if (b32.done_o !== 1'b1) begin
      errs++;
      $display("FAIL rerun_done got %b want 1", b32.done_o);
    end
    rd32(2'd0, v);
    vecs++;
    if (v !== 32'd8) begin
      errs++;
      $display("FAIL rerun_cycle got %0d want 8", v);
    end
  endtask

  task automatic test_stop();
    logic [31:0] v;
    launch32(32'd100);
    for (int c = 1; c <= 7; c++) begin
      b32.evt_i = {1'b0, (c <= 3)};
      b32.stop_i = (c == 7);
      tick();
    end
    b32.evt_i = 2'b00;
    b32.stop_i = 1'b0;
    vecs++;
    if (b32.done_o !== 1'b1) begin
      errs++;
      $display("FAIL stop_done got %b want 1", b32.done_o);
    end
    rd32(2'd0, v);
    vecs++;
    if (v !== 32'd7) begin
      errs++;
      $display("FAIL stop_cycle got %0d want 7", v);
    end
    rd32(2'd1, v);
    vecs++;
    if (v !== 32'd3) begin
      errs++;
      $display("FAIL stop_ch0 got %0d want 3", v);
    end
    b32.stop_i = 1'b1;
    b32.start_i = 1'b0;
    tick();
    vecs++;
    if (b32.done_o !== 1'b1) begin
      errs++;
      $display("FAIL stop_in_done got %b want 1", b32.done_o);
    end
    b32.start_i = 1'b1;
    tick();
    b32.stop_i = 1'b0;
    vecs++;
    if (b32.running_o !== 1'b1) begin
      errs++;
      $display("FAIL stop_start_relaunch got %b want 1", b32.running_o);
    end
    tick();
    vecs++;
    if (b32.rd_data_o !== 32'd0) begin
      errs++;
      $display("FAIL relaunch_ch0 got %0d want 0", b32.rd_data_o);
    end
    b32.rd_sel_i = 2'd0;
    tick();
    vecs++;
    if (b32.rd_data_o !== 32'd1) begin
      errs++;
      $display("FAIL relaunch_cycle got %0d want 1", b32.rd_data_o);
    end
    b32.stop_i = 1'b1;
    tick();
    b32.stop_i = 1'b0;
    rd32(2'd0, v);
    vecs++;
    if (v !== 32'd3 || b32.done_o !== 1'b1) begin
      errs++;
      $display("FAIL relaunch_end cyc=%0d done=%b want 3 1",
               v, b32.done_o);
    end
  endtask

  task automatic test_stop_at_limit();
    logic [31:0] v;
    launch32(32'd4);
    for (int c = 1; c <= 4; c++) begin
      b32.stop_i = (c == 4);
      tick();
    end
    b32.stop_i = 1'b0;
    tick();
    vecs++;
    if (b32.done_o !== 1'b1 || b32.running_o !== 1'b0) begin
      errs++;
      $display("FAIL stop_lim done=%b run=%b want 1 0",
               b32.done_o, b32.running_o);
    end
    rd32(2'd0, v);
    vecs++;
    if (v !== 32'd4) begin
      errs++;
      $display("FAIL stop_lim_cycle got %0d want 4", v);
    end
  endtask

  task automatic test_clear_collision();
    launch32(32'd0);
    b32.evt_i = 2'b01;
    tick(3);
    b32.clear_i = 1'b1;
    tick();
    b32.clear_i = 1'b0;
    b32.evt_i = 2'b00;
    vecs++;
    if (b32.running_o !== 1'b1) begin
      errs++;
      $display("FAIL clear_state run=%b want 1", b32.running_o);
    end
    b32.rd_sel_i = 2'd1;
    tick();
    vecs++;
    if (b32.rd_data_o !== 32'd0) begin
      errs++;
      $display("FAIL clear_ch0 got %0d want 0", b32.rd_data_o);
    end
    b32.rd_sel_i = 2'd0;
    tick();
    vecs++;
    if (b32.rd_data_o !== 32'd1) begin
      errs++;
      $display("FAIL clear_cycle got %0d want 1", b32.rd_data_o);
    end
    b32.stop_i = 1'b1;
    tick();
    b32.stop_i = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [31:0] v;
    b32.rd_sel_i = 2'd0;
    launch32(32'd0);
    tick(4);
    rst = 1'b1;
    b32.clear_i = 1'b1;
    b32.stop_i = 1'b1;
    tick();
    vecs++;
    if (b32.running_o !== 1'b0 || b32.done_o !== 1'b0 ||
        b32.rd_data_o !== 32'd0) begin
      errs++;
      $display("FAIL rst_mid run=%b done=%b rd=%0d want 0 0 0",
               b32.running_o, b32.done_o, b32.rd_data_o);
    end
    rst = 1'b0;
    b32.clear_i = 1'b0;
    b32.stop_i = 1'b0;
    tick(3);
    vecs++;
    if (b32.running_o !== 1'b0) begin
      errs++;
      $display("FAIL rst_hold_start run=%b want 0", b32.running_o);
    end
    rd32(2'd0, v);
    vecs++;
    if (v !== 32'd0) begin
      errs++;
      $display("FAIL rst_cycle got %0d want 0", v);
    end
    b32.start_i = 1'b0;
    tick();
    b32.start_i = 1'b1;
    tick();
    vecs++;
    if (b32.running_o !== 1'b1) begin
      errs++;
      $display("FAIL rst_relaunch run=%b want 1", b32.running_o);
    end
    b32.stop_i = 1'b1;
    tick();
    b32.stop_i = 1'b0;
  endtask

  task automatic test_saturation();
    logic [7:0] v;
    b8.limit_i = 8'd0;
    b8.evt_mask_i = 2'b11;
    b8.start_i = 1'b0;
    tick();
    b8.start_i = 1'b1;
    tick();
    b8.evt_i = 2'b10;
    tick(300);
    b8.evt_i = 2'b00;
    b8.stop_i = 1'b1;
    tick();
    b8.stop_i = 1'b0;
    vecs++;
    if (b8.done_o !== 1'b1 || b8.ovf_o !== 3'b101) begin
      errs++;
      $display("FAIL sat_flags done=%b ovf=%b want 1 101",
               b8.done_o, b8.ovf_o);
    end
    rd8(2'd0, v);
    vecs++;
    if (v !== 8'd255) begin
      errs++;
      $display("FAIL sat_cycle got %0d want 255", v);
    end
    rd8(2'd2, v);
    vecs++;
    if (v !== 8'd255) begin
      errs++;
      $display("FAIL sat_ch1 got %0d want 255", v);
    end
    rd8(2'd1, v);
    vecs++;
    if (v !== 8'd0) begin
      errs++;
      $display("FAIL sat_ch0 got %0d want 0", v);
    end
    b8.clear_i = 1'b1;
    tick();
    b8.clear_i = 1'b0;
    vecs++;
    if (b8.ovf_o !== 3'b000 || b8.done_o !== 1'b1) begin
      errs++;
      $display("FAIL sat_clear ovf=%b done=%b want 000 1",
               b8.ovf_o, b8.done_o);
    end
    rd8(2'd2, v);
    vecs++;
    if (v !== 8'd0) begin
      errs++;
      $display("FAIL sat_clear_ch1 got %0d want 0", v);
    end
  endtask

  initial begin
    b32.start_i = 1'b0;
    b32.stop_i = 1'b0;
    b32.clear_i = 1'b0;
    b32.evt_i = 2'b00;
    b32.evt_mask_i = 2'b11;
    b32.limit_i = 32'd0;
    b32.rd_sel_i = 2'd0;
    b8.start_i = 1'b0;
    b8.stop_i = 1'b0;
    b8.clear_i = 1'b0;
    b8.evt_i = 2'b00;
    b8.evt_mask_i = 2'b11;
    b8.limit_i = 8'd0;
    b8.rd_sel_i = 2'd0;
    test_reset();
    test_limit();
    test_mask();
    test_start_in_run();
    test_stop();
    test_stop_at_limit();
    test_clear_collision();
    test_reset_midrun();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
